// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the fifo1 read-side stream consumer
// Contents:
//   rd_state_t  FSM state encoding for fifo_rd_stream (IDLE, ACTIVE, STOPPING)
//   SKID_DEPTH  number of entries in the skid buffer behind the FIFO read port
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        STOPPING = 2'd2
    } rd_state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - 2-entry FIFO-ordered register buffer absorbing the FIFO read latency
// Ports:
//   clk        in   clock, state updates on posedge
//   rst        in   asynchronous active-high reset, empties the buffer
//   push       in   write push_data at the tail
//   push_data  in   [W] entry to store
//   pop        in   remove the head entry
//   count      out  [2] number of valid entries (0..2)
//   head       out  [W] oldest entry; all zero when the buffer is empty
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] ent0;
    logic [W-1:0] ent1;
    logic [1:0]   cnt;

    // Vacated entries are cleared so the head reads zero whenever the buffer is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    // The upstream credit check keeps a push away from a full buffer.
                    if (cnt == 2'd0) begin
                        ent0 <= push_data;
                        cnt  <= 2'd1;
                    end else if (cnt < 2'(SKID_DEPTH)) begin
                        ent1 <= push_data;
                        cnt  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt != 2'd0) begin
                        ent0 <= ent1;
                        ent1 <= '0;
                        cnt  <= cnt - 2'd1;
                    end
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end else begin
                        // With one entry the pushed word becomes the new head; with none,
                        // the pop is spurious and only the push takes effect.
                        ent0 <= push_data;
                        cnt  <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count = cnt;
    assign head  = ent0;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - fifo1 read-port consumer presenting a valid/ready stream with burst framing
// Build option: RD_PARITY_EN adds out_parity (even parity of out_data, stored per skid entry).
// Ports:
//   rclk       in   read-domain clock
//   reset      in   asynchronous active-high reset
//   enable     in   1 = fetch from the FIFO, 0 = stop fetching and drain
//   empty_bar  in   fifo1 holds at least one word
//   fifo_dout  in   [WIDTH] fifo1 data_out, valid the cycle after an accepted get
//   get        out  fifo1 read request
//   out_data   out  [WIDTH] stream data (skid head)
//   out_valid  out  stream valid
//   out_ready  in   stream ready
//   out_last   out  last word of a BURST_LEN-word burst
//   out_parity out  (RD_PARITY_EN only) ^out_data
//   busy       out  FSM not idle
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             enable,
    input  logic             empty_bar,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             get,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
`ifdef RD_PARITY_EN
    output logic             out_parity,
`endif
    output logic             busy
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
`ifdef RD_PARITY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    rd_state_t        state;
    rd_state_t        state_next;
    logic             inflight;
    logic [CNT_W-1:0] word_cnt;
    logic [1:0]       count;
    logic [EW-1:0]    push_entry;
    logic [EW-1:0]    head;
    logic             pop;
    logic [2:0]       credit;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;

    // Slots committed after this edge: buffered words, minus the one leaving, plus the one
    // already requested. A new get is only issued while that stays below the skid depth.
    assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign get    = (state == ACTIVE) & empty_bar & (credit < 3'(SKID_DEPTH));

`ifdef RD_PARITY_EN
    assign push_entry = {^fifo_dout, fifo_dout};
    assign out_parity = head[WIDTH];
`else
    assign push_entry = fifo_dout;
`endif
    assign out_data = head[WIDTH-1:0];
    assign out_last = out_valid & (word_cnt == LAST_CNT);
    assign busy     = (state != IDLE);

    skid_buf2 #(
        .W (EW)
    ) u_skid (
        .clk       (rclk),
        .rst       (reset),
        .push      (inflight),
        .push_data (push_entry),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            inflight <= 1'b0;
            word_cnt <= '0;
        end else begin
            state    <= state_next;
            inflight <= get;
            // Burst position survives stop/start; only reset rewinds it.
            if (pop) begin
                word_cnt <= (word_cnt == LAST_CNT) ? '0 : word_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = ACTIVE;
            end
            ACTIVE: begin
                if (!enable) state_next = STOPPING;
            end
            STOPPING: begin
                if (enable) begin
                    state_next = ACTIVE;
                end else if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream with a fifo1 read-port model
module tb_fifo_rd_stream;

    localparam int BL = 4;

    logic       rclk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       out_ready = 1'b0;
    logic       force_empty = 1'b0;
    logic       empty_bar;
    logic [7:0] fifo_dout = 8'h00;
    logic       get;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       busy;
`ifdef RD_PARITY_EN
    logic       out_parity;
    logic       pop_par_log[$];
`endif

    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'h00;
    logic [7:0] rd_ptr = 8'h00;

    int checks = 0;
    int errors = 0;

    // Scoreboard state: words fetched from the FIFO, in order, not yet seen leaving the stream.
    logic [7:0] exp_q[$];
    logic [7:0] pop_data_log[$];
    logic       pop_last_log[$];
    int         get_log[$];
    int         pop_idx = 0;
    int         cyc = 0;
    int         avail;
    bit         exp_v;
    bit         last_get = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    always #5 rclk = ~rclk;

    // fifo1 read port: one-cycle read latency, empty flag from pointer compare.
    assign empty_bar = !force_empty && (rd_ptr != wr_ptr);
    always @(posedge rclk) begin
        if (get) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    fifo_rd_stream #(.WIDTH(8), .BURST_LEN(BL)) dut (
        .rclk      (rclk),
        .reset     (reset),
        .enable    (enable),
        .empty_bar (empty_bar),
        .fifo_dout (fifo_dout),
        .get       (get),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
`ifdef RD_PARITY_EN
        .out_parity(out_parity),
`endif
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: sampled on the falling edge, i.e. the values the next rising edge will see.
    always @(negedge rclk) begin
        cyc++;
        if (reset) begin
            chk("rst_get", get, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_last", out_last, 0);
            chk("rst_busy", busy, 0);
`ifdef RD_PARITY_EN
            chk("rst_parity", out_parity, 0);
`endif
            exp_q.delete();
            pop_idx    = 0;
            last_get   = 0;
            prev_stall = 0;
        end else begin
            // A word fetched on the previous cycle is still on the FIFO data bus, not yet buffered.
            avail = int'(exp_q.size()) - (last_get ? 1 : 0);
            exp_v = (avail > 0);
            chk("valid", out_valid, exp_v);
            chk("last", out_last, exp_v && ((pop_idx % BL) == BL - 1));
            if (prev_stall) begin
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid && exp_v) begin
                chk("data", out_data, exp_q[0]);
`ifdef RD_PARITY_EN
                chk("parity", out_parity, ^exp_q[0]);
`endif
            end
            if (get) begin
                chk("get_when_empty", empty_bar, 1);
                chk("skid_overflow",
                    (int'(exp_q.size()) - ((out_valid && out_ready) ? 1 : 0) + 1) <= 2, 1);
            end
            if (out_valid && out_ready && exp_v) begin
                pop_data_log.push_back(out_data);
                pop_last_log.push_back(out_last);
`ifdef RD_PARITY_EN
                pop_par_log.push_back(out_parity);
`endif
                void'(exp_q.pop_front());
                pop_idx++;
            end
            if (get) begin
                exp_q.push_back(mem[rd_ptr]);
                get_log.push_back(cyc);
            end
            last_get   = get;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic preload(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = base + 8'(i);
            wr_ptr      = wr_ptr + 8'd1;
        end
    endtask

    task automatic wait_pops(input string name, input int target, input int bound);
        int n;
        n = 0;
        while (pop_data_log.size() < target && n < bound) begin
            step();
            n++;
        end
        chk(name, pop_data_log.size() >= target, 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 30) begin
            step();
            n++;
        end
        chk(name, busy, 0);
    endtask

    int p0;
    int g0;
    int g1;

    initial begin
        // 1: reset held 80 ns
        #42;
        chk("t1_get", get, 0);
        chk("t1_valid", out_valid, 0);
        chk("t1_last", out_last, 0);
        chk("t1_busy", busy, 0);
        #39;
        reset = 1'b0;
        step();

        // 2: 16 preloaded words streamed at full rate
        preload(8'h00, 16);
        p0 = pop_data_log.size();
        g0 = get_log.size();
        enable = 1'b1;
        out_ready = 1'b1;
        wait_pops("t2_timeout", p0 + 16, 80);
        chk("t2_gets", get_log.size() - g0, 16);
        if (get_log.size() >= g0 + 16) chk("t2_back_to_back", get_log[g0 + 15] - get_log[g0], 15);
        for (int i = 0; i < 16; i++) begin
            if (p0 + i < pop_data_log.size()) begin
                chk("t2_data", pop_data_log[p0 + i], i);
                chk("t2_last", pop_last_log[p0 + i], (i % 4) == 3);
            end
        end
`ifdef RD_PARITY_EN
        if (pop_par_log.size() > p0 + 7) begin
            chk("t2_parity_07", pop_par_log[p0 + 7], 1);
            chk("t2_parity_03", pop_par_log[p0 + 3], 0);
        end
`endif
        enable = 1'b0;
        wait_idle("t2_idle");

        // 3: backpressure holds the stream after exactly two fetches
        preload(8'h00, 8);
        p0 = pop_data_log.size();
        g0 = get_log.size();
        out_ready = 1'b0;
        enable = 1'b1;
        repeat (12) step();
        chk("t3_gets_stalled", get_log.size() - g0, 2);
        chk("t3_valid", out_valid, 1);
        chk("t3_head", out_data, 8'h00);
        out_ready = 1'b1;
        wait_pops("t3_timeout", p0 + 8, 40);
        for (int i = 0; i < 8; i++) begin
            if (p0 + i < pop_data_log.size()) chk("t3_data", pop_data_log[p0 + i], i);
        end
        chk("t3_gets_total", get_log.size() - g0, 8);
        enable = 1'b0;
        wait_idle("t3_idle");

        // 4: stop after the second pop, drain, resume; burst position carried over
        reset = 1'b1;
        step();
        reset = 1'b0;
        preload(8'h40, 6);
        p0 = pop_data_log.size();
        g0 = get_log.size();
        enable = 1'b1;
        out_ready = 1'b1;
        wait_pops("t4_timeout_a", p0 + 2, 20);
        enable = 1'b0;
        step();
        g1 = get_log.size();
        wait_idle("t4_idle");
        chk("t4_no_get_stopped", get_log.size(), g1);
        chk("t4_drained", pop_data_log.size() - p0, get_log.size() - g0);
        enable = 1'b1;
        wait_pops("t4_timeout_b", p0 + 6, 30);
        if (pop_data_log.size() >= p0 + 6) begin
            chk("t4_word3", pop_data_log[p0 + 3], 8'h43);
            chk("t4_last3", pop_last_log[p0 + 3], 1);
            chk("t4_last2", pop_last_log[p0 + 2], 0);
            chk("t4_last4", pop_last_log[p0 + 4], 0);
        end
        enable = 1'b0;
        wait_idle("t4_idle_b");

        // 5: FIFO reports empty with enable high
        preload(8'h50, 4);
        force_empty = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("t5_no_get", get, 0);
            chk("t5_no_valid", out_valid, 0);
        end
        force_empty = 1'b0;
        #1;
        chk("t5_get_same_cycle", get, 1);
        p0 = pop_data_log.size();
        wait_pops("t5_timeout", p0 + 4, 20);
        if (pop_data_log.size() >= p0 + 4) chk("t5_word3", pop_data_log[p0 + 3], 8'h53);

        // 6: asynchronous reset with two words buffered
        out_ready = 1'b0;
        step();
        preload(8'h60, 6);
        repeat (6) step();
        chk("t6_valid_pre", out_valid, 1);
        chk("t6_head_pre", out_data, 8'h60);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_get", get, 0);
        chk("t6_valid", out_valid, 0);
        chk("t6_data", out_data, 0);
        chk("t6_last", out_last, 0);
        chk("t6_busy", busy, 0);
        step();
        reset = 1'b0;
        p0 = pop_data_log.size();
        out_ready = 1'b1;
        wait_pops("t6_timeout", p0 + 4, 30);
        if (pop_data_log.size() >= p0 + 4) begin
            chk("t6_first", pop_data_log[p0], 8'h62);
            chk("t6_word3", pop_data_log[p0 + 3], 8'h65);
            chk("t6_last3", pop_last_log[p0 + 3], 1);
            chk("t6_last0", pop_last_log[p0], 0);
            chk("t6_last2", pop_last_log[p0 + 2], 0);
        end
        enable = 1'b0;
        wait_idle("t6_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
